// File: rtl/cpu_stream_pkg.sv
// Shared types for the CPU stream collector.
//   txn_cnt_t   : per-channel delivered-word counter (32 bit)
//   TXN_CNT_MAX : saturation value of txn_cnt_t
//   idx_w()     : width of a channel index, never less than one bit
//   arb_state_e : arbiter state (IDLE: no grant, GRANT: out_vld high)
package cpu_stream_pkg;

    typedef logic [31:0] txn_cnt_t;

    localparam txn_cnt_t TXN_CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_e;

    function automatic int idx_w(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_stream_fifo.sv
// Synchronous single-clock FIFO, one per channel of the stream collector.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset (flushes contents)
//   push       : write push_data when not full (ignored when full)
//   push_data  : write data
//   pop        : drop the head entry when not empty (ignored when empty)
//   full/empty : occupancy flags from the start-of-cycle count
//   head       : oldest entry; stable until popped
module cpu_stream_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            // Depth is a power of two, so pointers wrap by natural overflow.
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cpu_stream_arbiter.sv
// Merges CPU_NB per-channel word streams onto one valid/ready stream with a
// round-robin arbiter, and counts delivered words per channel.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_vld/data  : per-channel write request and data
//   in_rdy       : per-channel FIFO not full (low during reset)
//   out_vld/rdy  : merged output handshake
//   out_data/idx : merged word and its source channel (held while stalled)
//   txn_target   : expected words per channel (quasi-static)
//   txn_count    : saturating delivered-word counter per channel
//   done         : txn_count reached txn_target
//   all_done     : every channel done
module cpu_stream_arbiter
    import cpu_stream_pkg::*;
#(
    parameter int unsigned CPU_NB     = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned IDX_W     = idx_w(CPU_NB)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CPU_NB-1:0]             in_vld,
    input  logic [CPU_NB-1:0][DATA_W-1:0] in_data,
    output logic [CPU_NB-1:0]             in_rdy,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_W-1:0]             out_data,
    output logic [IDX_W-1:0]              out_idx,
    input  txn_cnt_t                      txn_target,
    output txn_cnt_t [CPU_NB-1:0]         txn_count,
    output logic [CPU_NB-1:0]             done,
    output logic                          all_done
);

    arb_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              grant_q, grant_d;
    logic [IDX_W-1:0]              last_q, last_d;
    txn_cnt_t [CPU_NB-1:0]         cnt_q, cnt_d;

    logic [CPU_NB-1:0]             full;
    logic [CPU_NB-1:0]             empty;
    logic [CPU_NB-1:0][DATA_W-1:0] head;
    logic [CPU_NB-1:0]             push;
    logic [CPU_NB-1:0]             pop;
    logic [CPU_NB-1:0]             avail;
    logic                          hs;
    logic [IDX_W-1:0]              scan_base;
    logic                          found;
    logic [IDX_W-1:0]              pick;

    assign in_rdy = ~full & {CPU_NB{~rst}};
    assign push   = in_vld & in_rdy;
    assign hs     = (state_q == GRANT) && out_rdy;

    for (genvar g = 0; g < int'(CPU_NB); g++) begin : g_ch
        cpu_stream_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[g]),
            .push_data(in_data[g]),
            .pop      (pop[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .head     (head[g])
        );

        // A write while in_rdy is low is lost; drivers must never do this.
        assert property (@(posedge clk) disable iff (rst) !(in_vld[g] && !in_rdy[g]))
            else $error("cpu_stream_arbiter: write to full channel %0d dropped", g);
    end

    // Pop and channel availability as seen after this cycle's handshake.
    always_comb begin
        pop   = '0;
        avail = '0;
        for (int i = 0; i < int'(CPU_NB); i++) begin
            pop[i]   = hs && (grant_q == IDX_W'(i));
            avail[i] = !empty[i] && !pop[i];
        end
    end

    // Round-robin scan starting after the most recently served channel. In
    // GRANT the base is the current grant, which becomes 'last' on handshake.
    always_comb begin
        int c;
        scan_base = (state_q == GRANT) ? grant_q : last_q;
        found     = 1'b0;
        pick      = '0;
        c         = 0;
        for (int k = 0; k < int'(CPU_NB); k++) begin
            c = (int'(scan_base) + 1 + k) % int'(CPU_NB);
            if (!found && avail[c]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    // Next-state logic. No re-decision while stalled in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = pick;
                end
            end
            GRANT: begin
                if (hs) begin
                    last_d = grant_q;
                    if (found) begin
                        grant_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating per-channel delivered-word counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < int'(CPU_NB); i++) begin
            if (pop[i] && (cnt_q[i] != TXN_CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + txn_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(CPU_NB - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced to zero outside GRANT so idle values are well defined.
    always_comb begin
        out_vld  = (state_q == GRANT);
        out_idx  = out_vld ? grant_q : '0;
        out_data = out_vld ? head[grant_q] : '0;
        for (int i = 0; i < int'(CPU_NB); i++) begin
            done[i] = (cnt_q[i] >= txn_target) && !rst;
        end
        all_done  = &done;
        txn_count = cnt_q;
    end

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
module tb_cpu_stream_arbiter;
    import cpu_stream_pkg::*;

    localparam int unsigned CPU_NB     = 4;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned IDX_W      = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [CPU_NB-1:0]             in_vld = '0;
    logic [CPU_NB-1:0][DATA_W-1:0] in_data = '0;
    logic [CPU_NB-1:0]             in_rdy;
    logic                          out_vld;
    logic                          out_rdy = 1'b0;
    logic [DATA_W-1:0]             out_data;
    logic [IDX_W-1:0]              out_idx;
    txn_cnt_t                      txn_target = 32'd5;
    txn_cnt_t [CPU_NB-1:0]         txn_count;
    logic [CPU_NB-1:0]             done;
    logic                          all_done;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: words pushed per channel, in order.
    logic [DATA_W-1:0] exp_q [CPU_NB][$];

    cpu_stream_arbiter #(
        .CPU_NB    (CPU_NB),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .txn_target(txn_target),
        .txn_count (txn_count),
        .done      (done),
        .all_done  (all_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want self-termination");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        for (int c = 0; c < int'(CPU_NB); c++) exp_q[c].delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_vld = '0; out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        @(negedge clk);
    endtask

    // Drive one write cycle on the channels in mask; record accepted words.
    task automatic push_words(input logic [CPU_NB-1:0] mask);
        for (int c = 0; c < int'(CPU_NB); c++) begin
            in_data[c] = {8'(c), 24'h5A_0000 | 24'($urandom_range(0, 65535)), $urandom()};
            if (mask[c] && in_rdy[c]) exp_q[c].push_back(in_data[c]);
        end
        in_vld = mask;
        @(negedge clk);
        in_vld = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_vld = '0; out_rdy = 1'b0; txn_target = 32'd5;
        @(negedge clk);
        n_vec++; if (in_rdy !== 4'h0) begin n_err++; $display("FAIL reset_in_rdy: got %h want 0", in_rdy); end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (out_idx !== '0) begin n_err++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        n_vec++; if (txn_count !== '0) begin n_err++; $display("FAIL reset_txn_count: got %h want 0", txn_count); end
        n_vec++; if (done !== 4'h0 || all_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %h/%b want 0/0", done, all_done); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_rdy !== 4'hF) begin n_err++; $display("FAIL post_reset_in_rdy: got %h want f", in_rdy); end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL post_reset_out_vld: got %b want 0", out_vld); end
        clear_sb();
    endtask

    task automatic test_target_zero();
        @(negedge clk);
        rst = 1'b1; txn_target = 32'd0;
        @(negedge clk);
        n_vec++; if (done !== 4'h0) begin n_err++; $display("FAIL zero_target_in_reset: got %h want 0", done); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (done !== 4'hF || all_done !== 1'b1) begin n_err++; $display("FAIL zero_target_done: got %h/%b want f/1", done, all_done); end
        txn_target = 32'd5;
        clear_sb();
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] exp;
        apply_reset();
        out_rdy = 1'b1;
        in_data[2] = 64'h0000_0000_DEAD_BEEF;
        in_vld = 4'b0100;
        exp_q[2].push_back(64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        in_vld = '0;
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_latency: got out_vld %b want 0", out_vld); end
        @(negedge clk);
        exp = exp_q[2].pop_front();
        n_vec++; if (out_vld !== 1'b1 || out_idx !== 2'd2) begin n_err++; $display("FAIL single_grant: got vld %b idx %0d want 1 2", out_vld, out_idx); end
        n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL single_data: got %h want %h", out_data, exp); end
        @(negedge clk);
        n_vec++; if (txn_count[2] !== 32'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", txn_count[2]); end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_idle: got out_vld %b want 0", out_vld); end
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] exp;
        int idx;
        apply_reset();
        for (int w = 0; w < 3; w++) push_words(4'hF);
        out_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (out_vld !== 1'b1 || out_idx !== IDX_W'(k % 4)) begin
                n_err++; $display("FAIL rr_order[%0d]: got vld %b idx %0d want 1 %0d", k, out_vld, out_idx, k % 4);
            end
            idx = int'(out_idx);
            if (out_vld === 1'b1 && exp_q[idx].size() > 0) begin
                exp = exp_q[idx].pop_front();
                n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, out_data, exp); end
            end
            @(negedge clk);
        end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rr_end: got out_vld %b want 0", out_vld); end
        out_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] snap;
        logic [DATA_W-1:0] exp;
        int order [3] = '{1, 3, 0};
        apply_reset();
        push_words(4'b1010);
        @(negedge clk);
        snap = exp_q[1][0];
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (out_vld !== 1'b1 || out_idx !== 2'd1 || out_data !== snap) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %b %0d %h want 1 1 %h", k, out_vld, out_idx, out_data, snap);
            end
            // A higher-priority channel filling mid-stall must not steal the grant.
            if (k == 1) push_words(4'b0001);
            else @(negedge clk);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_vld !== 1'b1 || out_idx !== IDX_W'(order[k])) begin
                n_err++; $display("FAIL release_order[%0d]: got vld %b idx %0d want 1 %0d", k, out_vld, out_idx, order[k]);
            end
            if (exp_q[order[k]].size() > 0) begin
                exp = exp_q[order[k]].pop_front();
                n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL release_data[%0d]: got %h want %h", k, out_data, exp); end
            end
            @(negedge clk);
        end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL release_end: got out_vld %b want 0", out_vld); end
        out_rdy = 1'b0;
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] exp;
        int got;
        apply_reset();
        for (int w = 0; w < int'(FIFO_DEPTH); w++) begin
            n_vec++; if (in_rdy[0] !== 1'b1) begin n_err++; $display("FAIL fill_rdy[%0d]: got %b want 1", w, in_rdy[0]); end
            push_words(4'b0001);
        end
        n_vec++; if (in_rdy[0] !== 1'b0) begin n_err++; $display("FAIL full_rdy: got %b want 0", in_rdy[0]); end
        n_vec++; if (in_rdy[1] !== 1'b1) begin n_err++; $display("FAIL full_other_rdy: got %b want 1", in_rdy[1]); end
        exp = exp_q[0].pop_front();
        n_vec++; if (out_vld !== 1'b1 || out_data !== exp) begin n_err++; $display("FAIL full_head: got %b %h want 1 %h", out_vld, out_data, exp); end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        n_vec++; if (in_rdy[0] !== 1'b1) begin n_err++; $display("FAIL after_pop_rdy: got %b want 1", in_rdy[0]); end
        // Refill wraps the write pointer around the end of storage.
        push_words(4'b0001);
        n_vec++; if (in_rdy[0] !== 1'b0) begin n_err++; $display("FAIL refull_rdy: got %b want 0", in_rdy[0]); end
        out_rdy = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && got < int'(FIFO_DEPTH); t++) begin
            if (out_vld === 1'b1) begin
                exp = (exp_q[0].size() > 0) ? exp_q[0].pop_front() : '0;
                n_vec++; if (out_idx !== 2'd0 || out_data !== exp) begin n_err++; $display("FAIL drain[%0d]: got %0d %h want 0 %h", got, out_idx, out_data, exp); end
                got++;
            end
            @(negedge clk);
        end
        n_vec++; if (got != int'(FIFO_DEPTH) || out_vld !== 1'b0) begin n_err++; $display("FAIL drain_count: got %0d vld %b want %0d 0", got, out_vld, FIFO_DEPTH); end
        out_rdy = 1'b0;
    endtask

    task automatic test_done();
        int cnt [CPU_NB];
        int hs;
        logic [DATA_W-1:0] exp;
        logic [CPU_NB-1:0] exp_done;
        apply_reset();
        txn_target = 32'd5;
        for (int c = 0; c < int'(CPU_NB); c++) cnt[c] = 0;
        for (int w = 0; w < 5; w++) push_words(4'hF);
        out_rdy = 1'b1;
        hs = 0;
        for (int t = 0; t < 40 && hs <= 20; t++) begin
            for (int c = 0; c < int'(CPU_NB); c++) exp_done[c] = (cnt[c] >= 5);
            n_vec++; if (done !== exp_done || all_done !== (&exp_done)) begin n_err++; $display("FAIL done_track[%0d]: got %h/%b want %h/%b", t, done, all_done, exp_done, &exp_done); end
            for (int c = 0; c < int'(CPU_NB); c++) begin
                n_vec++; if (txn_count[c] !== 32'(cnt[c])) begin n_err++; $display("FAIL count_track[%0d] ch%0d: got %0d want %0d", t, c, txn_count[c], cnt[c]); end
            end
            if (hs == 20) hs++;
            else if (out_vld === 1'b1) begin
                exp = (exp_q[out_idx].size() > 0) ? exp_q[out_idx].pop_front() : '0;
                n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL done_data[%0d]: got %h want %h", hs, out_data, exp); end
                cnt[out_idx]++;
                hs++;
            end
            @(negedge clk);
        end
        n_vec++; if (hs != 21 || all_done !== 1'b1) begin n_err++; $display("FAIL all_done: got hs %0d all_done %b want 20 1", hs - 1, all_done); end
        push_words(4'b0001);
        for (int t = 0; t < 5; t++) @(negedge clk);
        n_vec++; if (txn_count[0] !== 32'd6 || done[0] !== 1'b1) begin n_err++; $display("FAIL sixth_word: got %0d/%b want 6/1", txn_count[0], done[0]); end
        out_rdy = 1'b0;
    endtask

    task automatic test_midrun_reset();
        apply_reset();
        push_words(4'hF);
        @(negedge clk);
        n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL mid_loaded: got out_vld %b want 1", out_vld); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (out_vld !== 1'b0 || out_data !== '0 || out_idx !== '0) begin n_err++; $display("FAIL mid_reset_out: got %b %h %0d want 0 0 0", out_vld, out_data, out_idx); end
        n_vec++; if (in_rdy !== 4'h0 || txn_count !== '0 || done !== 4'h0) begin n_err++; $display("FAIL mid_reset_state: got %h %h %h want 0 0 0", in_rdy, txn_count, done); end
        rst = 1'b0;
        clear_sb();
        out_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n_vec++; if (out_vld !== 1'b0 || txn_count !== '0) begin n_err++; $display("FAIL mid_flushed[%0d]: got vld %b count %h want 0 0", t, out_vld, txn_count); end
        end
        n_vec++; if (in_rdy !== 4'hF) begin n_err++; $display("FAIL mid_in_rdy: got %h want f", in_rdy); end
        out_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_target_zero();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full();
        test_done();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
